// File: rtl/keccak_pad_absorb.sv
// rtl/keccak_pad_absorb.sv - message-to-rate-block assembler with Keccak pad10*1 (KECCAK_SHA3_DOMAIN_EN selects 0x06 suffix)
module keccak_pad_absorb #(
    parameter int RATE_WORDS = 9
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [63:0]              in_data,
    input  logic                     in_valid,
    input  logic                     in_last,
    input  logic [3:0]               in_nbytes,
    output logic                     in_ready,
    output logic [64*RATE_WORDS-1:0] out_block,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     out_first,
    output logic                     out_last
);

    localparam int BW     = 64 * RATE_WORDS;
    localparam int NBYTES = 8 * RATE_WORDS;
    localparam int CW     = $clog2(RATE_WORDS + 1);

`ifdef KECCAK_SHA3_DOMAIN_EN
    localparam logic [7:0] PAD_FIRST = 8'h06;
`else
    localparam logic [7:0] PAD_FIRST = 8'h01;
`endif

    typedef enum logic [1:0] {FILL, OUT, EXTRA} state_t;

    state_t          state, state_nxt;
    logic [CW-1:0]   word_cnt;
    logic [BW-1:0]   blk;
    logic            first_r, last_r, extra_pad;

    logic [63:0]     word_m;
    logic [BW-1:0]   fill_block;
    logic [BW-1:0]   extra_block;
    logic            no_pad;
    int              nb;
    int              pad_pos;

    // Byte b of the block: word b/8 counted from the top, byte b%8 from the word's LSB
    function automatic int byte_off(input int b);
        return 64 * (RATE_WORDS - 1 - b / 8) + 8 * (b % 8);
    endfunction

    // Build the block as it looks after writing the incoming word, padding it if it ends the message
    always_comb begin
        nb = 8;
        if (in_last && in_nbytes < 4'd8) nb = int'(in_nbytes);
        word_m = in_data;
        for (int j = 0; j < 8; j++) begin
            if (j >= nb) word_m[8*j +: 8] = 8'h00;
        end
        pad_pos    = 8 * int'(word_cnt) + nb;
        no_pad     = in_last && (pad_pos == NBYTES);
        fill_block = blk;
        fill_block[64*(RATE_WORDS-1-int'(word_cnt)) +: 64] = word_m;
        if (in_last) begin
            for (int w = 0; w < RATE_WORDS; w++) begin
                if (w > int'(word_cnt)) fill_block[64*(RATE_WORDS-1-w) +: 64] = 64'd0;
            end
            if (!no_pad) begin
                fill_block[byte_off(pad_pos) +: 8]    = fill_block[byte_off(pad_pos) +: 8] ^ PAD_FIRST;
                fill_block[byte_off(NBYTES-1) +: 8]   = fill_block[byte_off(NBYTES-1) +: 8] ^ 8'h80;
            end
        end
        extra_block = '0;
        extra_block[byte_off(0) +: 8]        = PAD_FIRST;
        extra_block[byte_off(NBYTES-1) +: 8] = extra_block[byte_off(NBYTES-1) +: 8] ^ 8'h80;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= FILL;
        else     state <= state_nxt;
    end

    // Next-state: a block leaves FILL when it is full or the message ends
    always_comb begin
        state_nxt = state;
        case (state)
            FILL:  if (in_valid && (in_last || word_cnt == CW'(RATE_WORDS - 1))) state_nxt = OUT;
            OUT:   if (out_ready) state_nxt = extra_pad ? EXTRA : FILL;
            EXTRA: if (out_ready) state_nxt = FILL;
            default: state_nxt = FILL;
        endcase
    end

    // Handshake outputs: filling and presenting never overlap
    always_comb begin
        in_ready  = (state == FILL);
        out_valid = (state != FILL);
    end

    // Block storage, word counter and block flags
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt  <= '0;
            blk       <= '0;
            first_r   <= 1'b1;
            last_r    <= 1'b0;
            extra_pad <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (in_valid) begin
                        blk <= fill_block;
                        if (in_last) begin
                            word_cnt  <= '0;
                            last_r    <= !no_pad;
                            extra_pad <= no_pad;
                        end else if (word_cnt == CW'(RATE_WORDS - 1)) begin
                            word_cnt <= '0;
                            last_r   <= 1'b0;
                        end else begin
                            word_cnt <= word_cnt + CW'(1);
                        end
                    end
                end
                OUT: begin
                    if (out_ready) begin
                        if (extra_pad) begin
                            blk       <= extra_block;
                            first_r   <= 1'b0;
                            last_r    <= 1'b1;
                            extra_pad <= 1'b0;
                        end else begin
                            first_r <= last_r;
                        end
                    end
                end
                EXTRA: begin
                    if (out_ready) begin
                        first_r <= 1'b1;
                        last_r  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign out_block = blk;
    assign out_first = first_r;
    assign out_last  = last_r;

endmodule
